gf_mul_const_133_148_16: RTL and testbench
==========================================

// Module: gf_mul_const_133_148_16
// PURPOSE
//  Registered GF(2^8) constant multiplier for the Kuznyechik L / inverse-L transform datapath.
//  - Multiplies one input byte by 0x85 (133), 0x94 (148) and 0x10 (16) in parallel.
//  - Field polynomial: x^8+x^7+x^6+x+1 (0x1C3).
//  - Replaces the per-constant combinational tables feeding the L-transform XOR tree; one byte lane per instance.
// PARAMETERS
//  POLY    9'h1C3  reduction polynomial, bit 8 set; fixed for Kuznyechik.
//  REG_OUT 1       1: products registered, 1-cycle latency; 0: products combinational, out_valid = in_valid.
// PORTS
//  clk        in   1  rising-edge clock; the block's only clock.
//  rst_n      in   1  asynchronous, active-low reset.
//  in_valid   in   1  qualifies in_byte.
//  in_byte    in   8  multiplicand a.
//  out_valid  out  1  qualifies the product outputs.
//  mul_133    out  8  a * 0x85 mod POLY.
//  mul_148    out  8  a * 0x94 mod POLY.
//  mul_16     out  8  a * 0x10 mod POLY.
//  xor_out    out  8  mul_133 ^ mul_148 ^ mul_16; present only with GF_MUL_XOR_OUT_EN.
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): out_valid=0 and all product outputs = 8'h00.
//    Reset takes effect immediately, independent of clk.
//  - Arithmetic: carry-less multiply. xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'hC3 : 8'h00).
//    - a*0x10 = xtime^4(a).
//    - a*0x85 = xtime^7(a) ^ xtime^2(a) ^ a.
//    - a*0x94 = xtime^7(a) ^ xtime^4(a) ^ xtime^2(a).
//    - Results are always 8 bits; no width growth.
//  - REG_OUT=1, each rising edge:
//    - out_valid <= in_valid.
//    - Products update only when in_valid=1; otherwise they hold their last value.
//    - Latency is exactly 1 cycle; throughput is 1 byte per cycle; there is no backpressure.
//  - REG_OUT=0: outputs are pure combinational functions of in_byte; reset does not affect them.
//  - Back-to-back valid bytes yield back-to-back results in order; no bubbles.
//  - Deasserting rst_n mid-stream discards any in-flight byte; the first result after reset
//    appears 1 cycle after the first in_valid sampled high.
//  - in_byte=0 yields all-zero products; 0x01 yields the constants themselves.
//  - No X propagation: in_byte is ignored while in_valid=0.
// CONFIGURATION
//  GF_MUL_XOR_OUT_EN defined:
//    - Adds output xor_out, registered/combinational consistently with REG_OUT.
//    - Because 0x85^0x94^0x10 = 0x01, xor_out always equals the captured in_byte.
//    - Reset value 8'h00.
//  GF_MUL_XOR_OUT_EN undefined: the xor_out port and its logic do not exist.
// TESTING
//  1. rst_n=0 with in_valid=1, in_byte=FF -> out_valid=0, all products 00 with no clk edge required.
//  2. in_byte=01, valid -> next cycle mul_133=85, mul_148=94, mul_16=10, out_valid=1.
//  3. in_byte=02 -> C9/EB/20; in_byte=80 -> mul_16=D7; in_byte=10 -> mul_16=C3.
//  4. Stream 00,01,02 on consecutive cycles -> results 00/00/00, 85/94/10, C9/EB/20
//     on consecutive cycles; then in_valid=0 -> out_valid=0, products hold C9/EB/20.
//  5. Exhaustive 00..FF versus a bitwise shift-and-xor reference model;
//     with GF_MUL_XOR_OUT_EN, check xor_out == in_byte.
//  6. Assert rst_n low while a result is in flight -> outputs clear at once;
//     first post-reset valid byte returns correct results after 1 cycle.

Source files
------------

// File: rtl/gf_mul_const_133_148_16_if.sv
// Byte-lane bus for the Kuznyechik constant multiplier.
// xor_out exists only when GF_MUL_XOR_OUT_EN is defined.
interface gf_mul_const_133_148_16_if;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       out_valid;
    logic [7:0] mul_133;
    logic [7:0] mul_148;
    logic [7:0] mul_16;
`ifdef GF_MUL_XOR_OUT_EN
    logic [7:0] xor_out;
`endif

    modport master (
        output in_valid,
        output in_byte,
        input  out_valid,
        input  mul_133,
        input  mul_148,
        input  mul_16
`ifdef GF_MUL_XOR_OUT_EN
        , input xor_out
`endif
    );

    modport slave (
        input  in_valid,
        input  in_byte,
        output out_valid,
        output mul_133,
        output mul_148,
        output mul_16
`ifdef GF_MUL_XOR_OUT_EN
        , output xor_out
`endif
    );
endinterface

// File: rtl/gf_mul_const_133_148_16.sv
// GF(2^8) multiply of one byte by 0x85, 0x94 and 0x10 for the Kuznyechik L-transform.
// Optional xor_out of the three products is enabled by defining GF_MUL_XOR_OUT_EN.
module gf_mul_const_133_148_16 #(
    parameter logic [8:0] POLY    = 9'h1C3,
    parameter bit         REG_OUT = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    gf_mul_const_133_148_16_if.slave     bus
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? POLY[7:0] : 8'h00);
    endfunction

    logic [7:0] x1_s, x2_s, x3_s, x4_s, x5_s, x6_s, x7_s;
    logic [7:0] mul_133_d, mul_148_d, mul_16_d;

    // Power-of-x chain shared by all three constant products.
    always_comb begin
        x1_s      = xtime(bus.in_byte);
        x2_s      = xtime(x1_s);
        x3_s      = xtime(x2_s);
        x4_s      = xtime(x3_s);
        x5_s      = xtime(x4_s);
        x6_s      = xtime(x5_s);
        x7_s      = xtime(x6_s);
        mul_133_d = x7_s ^ x2_s ^ bus.in_byte;
        mul_148_d = x7_s ^ x4_s ^ x2_s;
        mul_16_d  = x4_s;
    end

    if (REG_OUT) begin : g_reg
        logic       out_valid_q;
        logic [7:0] mul_133_q, mul_148_q, mul_16_q;
`ifdef GF_MUL_XOR_OUT_EN
        logic [7:0] xor_out_q;
`endif

        // Capture products on valid bytes; hold otherwise so idle inputs never leak through.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_q <= 1'b0;
                mul_133_q   <= 8'h00;
                mul_148_q   <= 8'h00;
                mul_16_q    <= 8'h00;
`ifdef GF_MUL_XOR_OUT_EN
                xor_out_q   <= 8'h00;
`endif
            end else begin
                out_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    mul_133_q <= mul_133_d;
                    mul_148_q <= mul_148_d;
                    mul_16_q  <= mul_16_d;
`ifdef GF_MUL_XOR_OUT_EN
                    xor_out_q <= mul_133_d ^ mul_148_d ^ mul_16_d;
`endif
                end else begin
                    mul_133_q <= mul_133_q;
                    mul_148_q <= mul_148_q;
                    mul_16_q  <= mul_16_q;
`ifdef GF_MUL_XOR_OUT_EN
                    xor_out_q <= xor_out_q;
`endif
                end
            end
        end

        assign bus.out_valid = out_valid_q;
        assign bus.mul_133   = mul_133_q;
        assign bus.mul_148   = mul_148_q;
        assign bus.mul_16    = mul_16_q;
`ifdef GF_MUL_XOR_OUT_EN
        assign bus.xor_out   = xor_out_q;
`endif
    end else begin : g_comb
        // Pure combinational lane: clock and reset play no part here.
        assign bus.out_valid = bus.in_valid;
        assign bus.mul_133   = mul_133_d;
        assign bus.mul_148   = mul_148_d;
        assign bus.mul_16    = mul_16_d;
`ifdef GF_MUL_XOR_OUT_EN
        assign bus.xor_out   = mul_133_d ^ mul_148_d ^ mul_16_d;
`endif
    end

endmodule

// File: tb/tb_gf_mul_const_133_148_16.sv
// Self-checking bench for gf_mul_const_133_148_16 (REG_OUT=1) against a
// polynomial-multiply-and-long-division reference model.
module tb_gf_mul_const_133_148_16;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    gf_mul_const_133_148_16_if bus ();

    gf_mul_const_133_148_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       exp_valid;
    logic [7:0] exp_133, exp_148, exp_16, exp_xor;

    // Carry-less product followed by long division by the field polynomial.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [15:0] poly;
        p    = 16'h0000;
        poly = 16'h01C3;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'({8'h00, a}) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (poly << (i - 8));
        return p[7:0];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, {7'h00, bus.out_valid}, {7'h00, exp_valid});
        check({tag, ".m133"}, bus.mul_133, exp_133);
        check({tag, ".m148"}, bus.mul_148, exp_148);
        check({tag, ".m16"},  bus.mul_16,  exp_16);
`ifdef GF_MUL_XOR_OUT_EN
        check({tag, ".xor"},  bus.xor_out, exp_xor);
`endif
    endtask

    // Drive one byte at a falling edge; the result is checked at the next falling edge.
    task automatic step(input logic v, input logic [7:0] b, input string tag);
        bus.in_valid = v;
        bus.in_byte  = b;
        @(negedge clk);
        exp_valid = v;
        if (v) begin
            exp_133 = ref_mul(b, 8'h85);
            exp_148 = ref_mul(b, 8'h94);
            exp_16  = ref_mul(b, 8'h10);
            exp_xor = b;
        end
        check_all(tag);
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_133   = 8'h00;
        exp_148   = 8'h00;
        exp_16    = 8'h00;
        exp_xor   = 8'h00;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();

        // Asynchronous reset with no clock edge in between.
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hFF;
        #1 rst_n = 1'b0;
        #1 check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'hFF, "idle");

        // Constants, with exact one-cycle latency.
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h01;
        #1 check("lat_early", {7'h00, bus.out_valid}, 8'h00);
        step(1'b1, 8'h01, "one");
        check("one.c133", bus.mul_133, 8'h85);
        check("one.c148", bus.mul_148, 8'h94);
        check("one.c16",  bus.mul_16,  8'h10);
        step(1'b1, 8'h02, "two");
        check("two.c133", bus.mul_133, 8'hC9);
        check("two.c148", bus.mul_148, 8'hEB);
        check("two.c16",  bus.mul_16,  8'h20);
        step(1'b1, 8'h80, "x80");
        check("x80.c16", bus.mul_16, 8'hD7);
        step(1'b1, 8'h10, "x10");
        check("x10.c16", bus.mul_16, 8'hC3);

        // Back-to-back stream then idle: products hold.
        step(1'b1, 8'h00, "s0");
        check("s0.zero", bus.mul_133 | bus.mul_148 | bus.mul_16, 8'h00);
        step(1'b1, 8'h01, "s1");
        step(1'b1, 8'h02, "s2");
        step(1'b0, 8'h5A, "hold0");
        check("hold.c133", bus.mul_133, 8'hC9);
        step(1'b0, 8'hA5, "hold1");

        // Exhaustive byte sweep.
        for (int i = 0; i < 256; i++) step(1'b1, 8'(i), "sweep");

        // Reset while a result is in flight.
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h3C;
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("mid_rst");
        @(negedge clk);
        check_all("mid_rst_hold");
        rst_n = 1'b1;
        step(1'b0, 8'h77, "post_rst_idle");
        step(1'b1, 8'h37, "post_rst_first");

        // Randomized valid/byte traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
